// File: rtl/rram_access_arbiter_if.sv
// rtl/rram_access_arbiter_if.sv - requester handshakes and RRAM array port of the access arbiter
// master = requesters plus array model, slave = arbiter.
interface rram_access_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          req0;
    logic          req1;
    logic [1:0]    op0;
    logic [1:0]    op1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          rram_ce_n;
    logic          rram_re;
    logic          rram_we;
    logic          rram_forming;
    logic [AW-1:0] rram_add;
    logic          rram_dout;
    logic          rram_doe;
    logic          rram_din;
    logic          verify_err;

    modport master (
        output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, rram_din,
        input  gnt0, gnt1, done0, done1, rdata, busy, rram_ce_n, rram_re, rram_we,
               rram_forming, rram_add, rram_dout, rram_doe, verify_err
    );

    modport slave (
        input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, rram_din,
        output gnt0, gnt1, done0, done1, rdata, busy, rram_ce_n, rram_re, rram_we,
               rram_forming, rram_add, rram_dout, rram_doe, verify_err
    );
endinterface

// File: rtl/rram_access_arbiter.sv
// rtl/rram_access_arbiter.sv - round-robin two-requester arbiter sequencing bit-serial RRAM transactions
// Optional write read-back check enabled by defining RRAM_WRITE_VERIFY_EN.
module rram_access_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int GAP_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    rram_access_arbiter_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
`ifdef RRAM_WRITE_VERIFY_EN
        S_GAP,
        S_VSETUP,
        S_VERIFY
`else
        S_GAP
`endif
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap_cnt;
    logic          id_q;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] shift_q;
    logic [DW-1:0] shift_nxt;
    logic [DW-1:0] rdata_q;
    logic          rr_ptr;
    logic          done0_q;
    logic          done1_q;
    logic          grant;
    logic          grant_id;
    logic          last_bit;
    logic          last_gap;
    logic          is_write;
    logic          is_form;
    logic          is_read;
    logic          in_access;
    logic          in_verify;
    logic          xfer_phase;
    logic          xfer_wr;
    logic          complete;

`ifdef RRAM_WRITE_VERIFY_EN
    logic          verify_pending;
    logic          verr_q;
    assign in_verify  = (state == S_VSETUP) || (state == S_VERIFY);
    assign xfer_phase = (state == S_XFER) || (state == S_VERIFY);
    // Writes finish only after their read-back pass.
    assign complete   = last_bit && (((state == S_XFER) && !is_write) || (state == S_VERIFY));
    assign bus.verify_err = verr_q;
`else
    assign in_verify  = 1'b0;
    assign xfer_phase = (state == S_XFER);
    assign complete   = last_bit && (state == S_XFER);
    assign bus.verify_err = 1'b0;
`endif

    assign last_bit  = (cnt == CW'(DW - 1));
    assign last_gap  = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign is_write  = (op_q == 2'b01);
    assign is_form   = (op_q == 2'b10);
    assign is_read   = !is_write && !is_form;
    assign in_access = (state == S_SETUP) || (state == S_XFER);
    assign xfer_wr   = (state == S_XFER) && is_write;

    always_comb begin
        shift_nxt      = shift_q;
        shift_nxt[cnt] = bus.rram_din;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant      = 1'b1;
                    grant_id   = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
                    next_state = S_SETUP;
                end
            end
            S_SETUP: next_state = S_XFER;
            S_XFER: begin
                if (last_bit) next_state = S_GAP;
            end
            S_GAP: begin
                if (last_gap) begin
`ifdef RRAM_WRITE_VERIFY_EN
                    next_state = verify_pending ? S_VSETUP : S_IDLE;
`else
                    next_state = S_IDLE;
`endif
                end
            end
`ifdef RRAM_WRITE_VERIFY_EN
            S_VSETUP: next_state = S_VERIFY;
            S_VERIFY: begin
                if (last_bit) next_state = S_GAP;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    assign bus.rram_ce_n    = !(in_access || in_verify);
    assign bus.rram_re      = (in_access && is_read) || in_verify;
    assign bus.rram_we      = in_access && is_write;
    assign bus.rram_forming = in_access && is_form;
    assign bus.rram_doe     = xfer_wr;
    assign bus.rram_dout    = xfer_wr && wdata_q[cnt];
    assign bus.rram_add     = addr_q;
    assign bus.gnt0         = (state == S_SETUP) && !id_q;
    assign bus.gnt1         = (state == S_SETUP) && id_q;
    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            id_q    <= 1'b0;
            op_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            rr_ptr  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef RRAM_WRITE_VERIFY_EN
            verify_pending <= 1'b0;
            verr_q         <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            done0_q <= complete && !id_q;
            done1_q <= complete && id_q;
            cnt     <= (xfer_phase && !last_bit) ? cnt + 1'b1 : '0;
            gap_cnt <= ((state == S_GAP) && !last_gap) ? gap_cnt + 1'b1 : '0;
            if (grant) begin
                id_q    <= grant_id;
                op_q    <= grant_id ? bus.op1 : bus.op0;
                addr_q  <= grant_id ? bus.addr1 : bus.addr0;
                wdata_q <= grant_id ? bus.wdata1 : bus.wdata0;
                rr_ptr  <= !grant_id;
            end
            if (xfer_phase) shift_q <= shift_nxt;
            if (complete && is_read) rdata_q <= shift_nxt;
`ifdef RRAM_WRITE_VERIFY_EN
            verr_q <= (state == S_VERIFY) && last_bit && (shift_nxt != wdata_q);
            if ((state == S_XFER) && last_bit && is_write) verify_pending <= 1'b1;
            else if ((state == S_VERIFY) && last_bit) verify_pending <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_rram_access_arbiter.sv
// tb/tb_rram_access_arbiter.sv - randomized bench for rram_access_arbiter against a transaction-level model
module tb_rram_access_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int GAP = 1;
`ifdef RRAM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;
        bit            abandon;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rram_access_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    rram_access_arbiter #(.DW(DW), .AW(AW), .GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

    txn_t          q0[$];
    txn_t          q1[$];
    txn_t          slot[2];
    bit            slot_valid[2];
    bit            granted[2];
    int            age[2];
    int            wait_cnt[2];
    logic [DW-1:0] mem[2**AW];
    logic [DW-1:0] rdata_exp;
    logic [DW-1:0] fault_mask;
    bit            act;
    bit            act_id;
    txn_t          act_t;
    bit            ptr;
    int            g_cyc, ph2_cyc, done_cyc, free_at, busy_from;
    int            cyc;
    int            checks;
    int            failures;
    int            gnt_ids[$];
    int            gnt_cycs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 1) ? q1.size() : q0.size();
    endfunction

    function automatic txn_t qhead(input int i);
        return (i == 1) ? q1[0] : q0[0];
    endfunction

    task automatic push(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int delay, input bit abandon);
        txn_t t;
        t = '{op, addr, wdata, delay, abandon};
        if (i == 1) q1.push_back(t);
        else q0.push_back(t);
    endtask

    // Cycle offset inside an array-select window of the active transaction, or -1.
    function automatic int phase_of(input int c, output bit second);
        second = 1'b0;
        if (!act) return -1;
        if (c >= g_cyc && c <= g_cyc + DW) return c - g_cyc;
        if (ph2_cyc >= 0 && c >= ph2_cyc && c <= ph2_cyc + DW) begin
            second = 1'b1;
            return c - ph2_cyc;
        end
        return -1;
    endfunction

    task automatic step();
        bit            sec;
        bit            w;
        int            k;
        logic [11:0]   got_v;
        logic [11:0]   exp_v;
        logic          e_ce_n, e_re, e_we, e_form, e_doe, e_dout, e_busy, e_verr;
        logic          e_g0, e_g1, e_d0, e_d1;
        logic [DW-1:0] rb;
        @(posedge clk);
        #1;
        cyc++;
        if (act && cyc == done_cyc) begin
            if (act_t.op == 2'b01) mem[act_t.addr] = act_t.wdata;
            if (act_t.op == 2'b00 || act_t.op == 2'b11) rdata_exp = mem[act_t.addr];
        end
        k = phase_of(cyc, sec);
        {e_ce_n, e_re, e_we, e_form, e_doe, e_dout} = 6'b100000;
        if (k >= 0) begin
            e_ce_n = 1'b0;
            if (sec) e_re = 1'b1;
            else if (act_t.op == 2'b01) e_we = 1'b1;
            else if (act_t.op == 2'b10) e_form = 1'b1;
            else e_re = 1'b1;
            if (!sec && act_t.op == 2'b01 && k >= 1) begin
                e_doe  = 1'b1;
                e_dout = act_t.wdata[k-1];
            end
        end
        e_g0   = act && cyc == g_cyc && !act_id;
        e_g1   = act && cyc == g_cyc && act_id;
        e_d0   = act && cyc == done_cyc && !act_id;
        e_d1   = act && cyc == done_cyc && act_id;
        e_verr = act && cyc == done_cyc && VERIFY && act_t.op == 2'b01
                 && ((act_t.wdata & ~fault_mask) != act_t.wdata);
        e_busy = (cyc >= busy_from) && (cyc < free_at);
        exp_v = {e_ce_n, e_re, e_we, e_form, e_doe, e_dout, e_g0, e_g1, e_d0, e_d1, e_busy, e_verr};
        got_v = {bus.rram_ce_n, bus.rram_re, bus.rram_we, bus.rram_forming, bus.rram_doe, bus.rram_dout,
                 bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.verify_err};
        check("ctl", got_v, exp_v);
        check("rdata", bus.rdata, rdata_exp);
        if (k >= 0) check("add", bus.rram_add, act_t.addr);
        if (bus.gnt0) begin gnt_ids.push_back(0); gnt_cycs.push_back(cyc); end
        if (bus.gnt1) begin gnt_ids.push_back(1); gnt_cycs.push_back(cyc); end
        if (act && cyc == done_cyc) begin
            act = 1'b0;
            granted[act_id] = 1'b0;
            slot_valid[act_id] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (slot_valid[i]) begin
                age[i]++;
                if (slot[i].abandon && age[i] >= 1) slot_valid[i] = 1'b0;
            end else if (!granted[i] && qsize(i) > 0) begin
                if (wait_cnt[i] < qhead(i).delay) wait_cnt[i]++;
                else begin
                    slot[i] = qhead(i);
                    if (i == 1) void'(q1.pop_front());
                    else void'(q0.pop_front());
                    slot_valid[i] = 1'b1;
                    age[i] = 0;
                    wait_cnt[i] = 0;
                end
            end
        end
        bus.req0 = slot_valid[0];   bus.req1 = slot_valid[1];
        bus.op0 = slot[0].op;       bus.op1 = slot[1].op;
        bus.addr0 = slot[0].addr;   bus.addr1 = slot[1].addr;
        bus.wdata0 = slot[0].wdata; bus.wdata1 = slot[1].wdata;
        if (!rst && !act && cyc >= free_at && (slot_valid[0] || slot_valid[1])) begin
            w = (slot_valid[0] && slot_valid[1]) ? ptr : slot_valid[1];
            ptr = !w;
            act = 1'b1;
            act_id = w;
            act_t = slot[w];
            granted[w] = 1'b1;
            g_cyc = cyc + 1;
            busy_from = g_cyc;
            if (VERIFY && act_t.op == 2'b01) begin
                ph2_cyc  = g_cyc + DW + 1 + GAP;
                done_cyc = ph2_cyc + DW + 1;
            end else begin
                ph2_cyc  = -1;
                done_cyc = g_cyc + DW + 1;
            end
            free_at = done_cyc + GAP;
        end
        k = phase_of(cyc, sec);
        if (k >= 1 && (sec || act_t.op == 2'b00 || act_t.op == 2'b11)) begin
            rb = sec ? (act_t.wdata & ~fault_mask) : mem[act_t.addr];
            bus.rram_din = rb[k-1];
        end else begin
            bus.rram_din = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_all(input int budget);
        int n;
        n = 0;
        while ((act || slot_valid[0] || slot_valid[1] || granted[0] || granted[1] ||
                q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < budget) begin
            step();
            n++;
        end
        check("drain", (n < budget), 1'b1);
    endtask

    initial begin
        bit found;
        checks = 0; failures = 0; cyc = 0;
        act = 1'b0; ptr = 1'b0; act_id = 1'b0;
        g_cyc = -10; ph2_cyc = -1; done_cyc = -10; free_at = 0; busy_from = 0;
        rdata_exp = '0; fault_mask = '0;
        for (int i = 0; i < 2; i++) begin
            slot_valid[i] = 1'b0; granted[i] = 1'b0; age[i] = 0; wait_cnt[i] = 0;
            slot[i] = '{2'b00, '0, '0, 0, 1'b0};
        end
        act_t = slot[0];
        for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 2'b00; bus.op1 = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.rram_din = 1'b0;

        step();
        check("rst_add", bus.rram_add, '0);
        step();
        rst = 1'b0;

        mem[3] = 32'hB6DB_6DB6;
        push(0, 2'b00, AW'(3), DW'($urandom), 0, 1'b0);
        run_all(200);
        check("t1_rdata", bus.rdata, 32'hB6DB_6DB6);

        push(1, 2'b01, AW'($urandom), 32'hA5A5_0F0F, 0, 1'b0);
        run_all(300);

        gnt_ids.delete();
        gnt_cycs.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 2'b00, AW'($urandom), '0, 0, 1'b0);
            push(1, 2'b00, AW'($urandom), '0, 0, 1'b0);
        end
        run_all(400);
        check("t3_ngnt", gnt_ids.size(), 4);
        for (int i = 0; i < 4 && i < gnt_ids.size(); i++) begin
            check("t3_order", gnt_ids[i], i % 2);
            if (i > 0) check("t3_spacing", gnt_cycs[i] - gnt_cycs[i-1], DW + GAP + 2);
        end

        push(1, 2'b10, AW'($urandom), DW'($urandom), 0, 1'b0);
        run_all(200);

        push(0, 2'b01, AW'(9), DW'($urandom), 0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            if (act && act_t.op == 2'b01 && cyc == g_cyc + 11) found = 1'b1;
        end
        check("t5_reach", found, 1'b1);
        rst = 1'b1;
        bus.req0 = 1'b0;
        slot_valid[act_id] = 1'b0;
        granted[act_id] = 1'b0;
        act = 1'b0;
        ptr = 1'b0;
        rdata_exp = '0;
        free_at = cyc + 1;
        step();
        check("t5_ce_n", bus.rram_ce_n, 1'b1);
        check("t5_add", bus.rram_add, '0);
        rst = 1'b0;
        push(0, 2'b00, AW'($urandom), '0, 0, 1'b0);
        run_all(200);

        fault_mask = 32'h0000_0008;
        push(0, 2'b01, AW'($urandom), 32'h0000_FFFF, 0, 1'b0);
        run_all(300);
        fault_mask = '0;
        push(0, 2'b01, AW'($urandom), 32'h0000_FFFF, 0, 1'b0);
        run_all(300);

        for (int i = 0; i < 40; i++) begin
            push(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0));
        end
        run_all(40 * 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
